// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-subset CPU: sequences PC, memory, IR,
// register file, ALU and immediate extender, stalling memory states on mem_ready.
module multicycle_ctrl #(
  parameter int unsigned OPW = 6,
  parameter int unsigned SW  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           ext_sign,
  output logic           illegal_op,
  output logic [SW-1:0]  state
);

  typedef enum logic [SW-1:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPE_EX,
    RTYPE_WB,
    ITYPE_EX,
    ITYPE_WB,
    BRANCH,
    JUMP
  } state_t;

  localparam logic [OPW-1:0] OP_R    = 6'b000000;
  localparam logic [OPW-1:0] OP_LW   = 6'b100011;
  localparam logic [OPW-1:0] OP_SW   = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE  = 6'b000101;
  localparam logic [OPW-1:0] OP_J    = 6'b000010;
  localparam logic [OPW-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPW-1:0] OP_SLTI = 6'b001010;
  localparam logic [OPW-1:0] OP_ANDI = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI  = 6'b001101;

  state_t state_q, state_d;
  logic   op_legal;
  logic   op_unsigned_imm;

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
    op_unsigned_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                        state_d = MEMADR;
          OP_R:                                state_d = RTYPE_EX;
          OP_BEQ, OP_BNE:                      state_d = BRANCH;
          OP_J:                                state_d = JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:   state_d = ITYPE_EX;
          default:                             state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:    state_d = mem_ready ? FETCH : MEMWR;
      RTYPE_EX: state_d = RTYPE_WB;
      ITYPE_EX: state_d = ITYPE_WB;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Moore decode of state_q; FETCH strobes are also gated by rst_n so that
  // no write fires while reset is held, even with mem_ready high.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    ext_sign      = 1'b1;
    illegal_op    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready & rst_n;
        ir_write  = mem_ready & rst_n;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        ext_sign   = ~op_unsigned_imm;
        illegal_op = ~op_legal;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      RTYPE_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ITYPE_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        ext_sign  = ~op_unsigned_imm;
      end
      ITYPE_WB: begin
        reg_write = 1'b1;
        ext_sign  = ~op_unsigned_imm;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS-subset CPU. It takes the opcode from the instruction register and sequences the shared datapath: PC, memory, IR, register file, ALU and the 16→32 immediate extender, across fetch/decode/execute/memory/writeback states. It also drives the extender mode so that one extender unit serves both signed and unsigned immediates. Memory accesses stall on a ready handshake.

Parameters:
OPW, 6, opcode field width (fixed for the MIPS encoding; must not be overridden)
SW, 4, state register width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
zero  input  1  ALU zero flag, used in BRANCH
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if branch condition is true (zero for beq, ~zero for bne; already resolved internally)
iord  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
mem_to_reg  output  1  register-file write data: 1 = MDR, 0 = ALUOut
reg_dst  output  1  destination register: 1 = rd, 0 = rt
reg_write  output  1  register-file write enable
alu_src_a  output  1  ALU A input: 0 = PC, 1 = rs
alu_src_b  output  2  ALU B input: 00 = rt, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
alu_op  output  2  00 = add, 01 = sub, 10 = use funct, 11 = use opcode (I-type ALU)
pc_source  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
ext_sign  output  1  1 = sign-extend the immediate, 0 = zero-extend it
illegal_op  output  1  one-cycle pulse on an unrecognised opcode
state  output  SW  current state, for debug

Behaviour:
- Reset:
  - rst_n low forces state = FETCH asynchronously, regardless of any access in progress.
  - While in reset, every output is 0 except mem_read = 1, alu_src_b = 01 and ext_sign = 1.
  - No write strobe may be high during or immediately after reset.
- Output style: Moore decode of the registered state. The exceptions are pc_write/ir_write in FETCH and pc_write_cond in BRANCH, which are additionally qualified by inputs as stated below.
- Supported opcodes:
  - R = 000000
  - lw = 100011, sw = 101011
  - beq = 000100, bne = 000101
  - j = 000010
  - addi = 001000, slti = 001010, andi = 001100, ori = 001101
- ext_sign:
  - 0 only for andi/ori, decoded from opcode in DECODE, ITYPE_EX and ITYPE_WB.
  - 1 in all other states and for all other opcodes.
- States and outputs (unlisted outputs are 0):
  - FETCH:
    - mem_read = 1, alu_src_b = 01, alu_op = 00, pc_source = 00.
    - ir_write = pc_write = mem_ready.
    - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
  - DECODE:
    - alu_src_b = 11, alu_op = 00 (branch target computed into ALUOut).
    - Next state by opcode: lw/sw → MEMADR; R → RTYPE_EX; beq/bne → BRANCH; j → JUMP; I-ALU → ITYPE_EX.
    - Any other opcode → FETCH, with illegal_op = 1 for this cycle.
  - MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. lw → MEMRD; sw → MEMWR.
  - MEMRD: iord = 1, mem_read = 1. Holds until mem_ready = 1, then → MEMWB.
  - MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0 → FETCH.
  - MEMWR: iord = 1, mem_write = 1. Holds until mem_ready = 1, then → FETCH. mem_write stays high for every cycle of the hold.
  - RTYPE_EX: alu_src_a = 1, alu_src_b = 00, alu_op = 10 → RTYPE_WB.
  - RTYPE_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0 → FETCH.
  - ITYPE_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 11 → ITYPE_WB.
  - ITYPE_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0 → FETCH.
  - BRANCH:
    - alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01.
    - pc_write_cond = zero for beq, ~zero for bne.
    - → FETCH.
  - JUMP: pc_write = 1, pc_source = 10 → FETCH.
- Latency with mem_ready held at 1, in cycles from FETCH entry to the next FETCH entry:
  - lw = 5
  - sw, R, I-ALU = 4
  - beq, bne, j = 3
  - Each cycle mem_ready is low adds 1 cycle to FETCH, MEMRD or MEMWR.
- Exclusivity:
  - mem_read and mem_write are never both high.
  - reg_write and pc_write are never high in the same state.
- State encoding: unused state codes → FETCH on the next clock.
- Reset mid-operation: any state aborts to FETCH immediately; no partial write completes after rst_n rises.

Test Plan:
- Reset: hold rst_n = 0 across a clk edge → state = FETCH, mem_read = 1, alu_src_b = 01, reg_write/mem_write/pc_write = 0. Release with mem_ready = 1 → pc_write = ir_write = 1 in the first cycle.
- R-type (opcode 000000), mem_ready = 1 → states FETCH, DECODE, RTYPE_EX, RTYPE_WB, FETCH. reg_write = 1 with reg_dst = 1 only in cycle 4.
- lw with mem_ready low for 3 cycles in MEMRD → MEMRD lasts 4 cycles, total 8 cycles. mem_to_reg = 1 in MEMWB.
- sw with mem_ready = 0 in FETCH for 2 cycles → ir_write is 0 until mem_ready = 1. mem_write held through MEMWR. Total 6 cycles.
- Branches:
  - beq with zero = 1 → pc_write_cond = 1; zero = 0 → pc_write_cond = 0.
  - bne inverts both results.
  - ori (001101) → ext_sign = 0 in DECODE and ITYPE_EX. addi → ext_sign = 1.
- Illegal opcode 111111 → illegal_op pulses for 1 cycle in DECODE, then FETCH. Asserting rst_n = 0 mid-MEMWR → mem_write drops immediately and state = FETCH.
